// File: rtl/npu_pkg.sv
// Shared definitions for the NPU front end: window-fetch FSM states and
// the 3x3 window geometry used by the fetcher and the convolver.
package npu_pkg;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        CAPTURE   = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } fetchState_e;

    localparam int WIN_DIM  = 3;
    localparam int WIN_SIZE = WIN_DIM * WIN_DIM;

endpackage

// File: rtl/line_buffer3.sv
// Three stacked line buffers: a write at column c shifts that column up by one
// row (lb0 oldest, lb2 newest) and every column of every row is readable.
module line_buffer3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int COL_W      = 3
) (
    input  logic                            clk_i,
    input  logic                            wrEn_i,
    input  logic [COL_W-1:0]                wrCol_i,
    input  logic [DATA_WIDTH-1:0]           wrData_i,
    output logic [IMG_WIDTH*DATA_WIDTH-1:0] row0_o,
    output logic [IMG_WIDTH*DATA_WIDTH-1:0] row1_o,
    output logic [IMG_WIDTH*DATA_WIDTH-1:0] row2_o
);

    logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];

    // Contents survive reset on purpose; a new frame overwrites them before use.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            lb0_q[wrCol_i] <= lb1_q[wrCol_i];
            lb1_q[wrCol_i] <= lb2_q[wrCol_i];
            lb2_q[wrCol_i] <= wrData_i;
        end
    end

    for (genvar c = 0; c < IMG_WIDTH; c++) begin : g_rd
        assign row0_o[c*DATA_WIDTH +: DATA_WIDTH] = lb0_q[c];
        assign row1_o[c*DATA_WIDTH +: DATA_WIDTH] = lb1_q[c];
        assign row2_o[c*DATA_WIDTH +: DATA_WIDTH] = lb2_q[c];
    end

endmodule

// File: rtl/window_fetcher.sv
// Streams raster pixels into three line buffers and, every second column from
// row 2 on, hands an overlapping pair of 3x3 windows to the convolver.
module window_fetcher
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int IMG_WIDTH       = 8,
    parameter int IMG_HEIGHT      = 8,
    parameter int SRAM_ADDR_WIDTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_pix_valid,
    input  logic [DATA_WIDTH-1:0]      i_pix_data,
    output logic                       o_pix_ready,
    output logic                       o_conv_start,
    input  logic                       i_conv_done,
    input  logic [SRAM_ADDR_WIDTH-1:0] i_window_addr,
    output logic [DATA_WIDTH-1:0]      o_window1_data,
    output logic [DATA_WIDTH-1:0]      o_window2_data,
    output logic                       o_frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    fetchState_e           state_q;
    logic [COL_W-1:0]      col_q, col_d, capCol_q;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  lastWin_q;
    logic                  pixReady_q, convStart_q, frameDone_q;
    logic [DATA_WIDTH-1:0] window1_q [WIN_SIZE];
    logic [DATA_WIDTH-1:0] window2_q [WIN_SIZE];

    logic                            accept, trigger;
    logic [IMG_WIDTH*DATA_WIDTH-1:0] lbRow [WIN_DIM];
    logic [3:0]                      winIdx;

    assign accept  = i_pix_valid & pixReady_q;
    assign trigger = accept && (row_q >= ROW_W'(2)) && col_q[0] && (col_q >= COL_W'(3));

    line_buffer3 #(
        .DATA_WIDTH(DATA_WIDTH),
        .IMG_WIDTH (IMG_WIDTH),
        .COL_W     (COL_W)
    ) u_lines (
        .clk_i   (i_clk),
        .wrEn_i  (accept),
        .wrCol_i (col_q),
        .wrData_i(i_pix_data),
        .row0_o  (lbRow[0]),
        .row1_o  (lbRow[1]),
        .row2_o  (lbRow[2])
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // The trigger pixel is written on the same edge that enters CAPTURE, so the
    // capture one cycle later sees the complete right-hand column.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= FILL;
            pixReady_q  <= 1'b1;
            convStart_q <= 1'b0;
            frameDone_q <= 1'b0;
            capCol_q    <= '0;
            lastWin_q   <= 1'b0;
            for (int i = 0; i < WIN_SIZE; i++) begin
                window1_q[i] <= '0;
                window2_q[i] <= '0;
            end
        end else begin
            convStart_q <= 1'b0;
            frameDone_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (trigger) begin
                        state_q    <= CAPTURE;
                        pixReady_q <= 1'b0;
                        capCol_q   <= col_q;
                        lastWin_q  <= (row_q == ROW_W'(IMG_HEIGHT - 1)) &&
                                      (col_q == COL_W'(IMG_WIDTH - 1));
                    end
                end
                CAPTURE: begin
                    for (int r = 0; r < WIN_DIM; r++) begin
                        for (int k = 0; k < WIN_DIM; k++) begin
                            window1_q[WIN_DIM*r+k] <=
                                lbRow[r][(int'(capCol_q) - 3 + k)*DATA_WIDTH +: DATA_WIDTH];
                            window2_q[WIN_DIM*r+k] <=
                                lbRow[r][(int'(capCol_q) - 2 + k)*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    state_q     <= START;
                    convStart_q <= 1'b1;
                end
                START: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_conv_done) begin
                        state_q     <= FILL;
                        pixReady_q  <= 1'b1;
                        frameDone_q <= lastWin_q;
                    end
                end
                default: begin
                    state_q    <= FILL;
                    pixReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign winIdx = i_window_addr[3:0];

    always_comb begin
        o_window1_data = '0;
        o_window2_data = '0;
        if (i_window_addr < SRAM_ADDR_WIDTH'(WIN_SIZE)) begin
            o_window1_data = window1_q[winIdx];
            o_window2_data = window2_q[winIdx];
        end
    end

    assign o_pix_ready  = pixReady_q;
    assign o_conv_start = convStart_q;
    assign o_frame_done = frameDone_q;

endmodule

// File: doc/window_fetcher.md
WINDOW_FETCHER -- requirements
Module: window_fetcher

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, pixel/window data width.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 8, pixels per row; even and at least 4.
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 8, rows per frame; at least 3.
REQ-004 The block SHALL have parameter SRAM_ADDR_WIDTH, default 4, window read address width.
REQ-005 The block SHALL have port i_clk, input, 1, clock; all state changes on rising edge.
REQ-006 The block SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-007 The block SHALL have port i_pix_valid, input, 1, raster pixel offered.
REQ-008 The block SHALL have port i_pix_data, input, DATA_WIDTH, raster pixel value.
REQ-009 The block SHALL have port o_pix_ready, output, 1, pixel accepted when valid and ready both high.
REQ-010 The block SHALL have port o_conv_start, output, 1, window pair ready for the convolver.
REQ-011 The block SHALL have port i_conv_done, input, 1, one-cycle convolver completion pulse.
REQ-012 The block SHALL have port i_window_addr, input, SRAM_ADDR_WIDTH, window read address from the convolver.
REQ-013 The block SHALL have ports o_window1_data and o_window2_data, output, DATA_WIDTH each, window read data.
REQ-014 The block SHALL have port o_frame_done, output, 1, one-cycle pulse at end of frame.

Function
REQ-015 The block SHALL hold three line buffers lb0/lb1/lb2, each IMG_WIDTH deep; on acceptance at column c, lb0[c]<=lb1[c], lb1[c]<=lb2[c], lb2[c]<=pixel.
REQ-016 The block SHALL track column counter col and row counter row; on acceptance col increments and wraps to 0 after IMG_WIDTH-1; row increments on col wrap and wraps to 0 after IMG_HEIGHT-1.
REQ-017 The block SHALL implement FSM states FILL, CAPTURE, START, WAIT_DONE.
REQ-018 In FILL, o_pix_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 FILL SHALL go to CAPTURE on acceptance of a pixel with row>=2, col odd and col>=3; otherwise it SHALL stay in FILL.
REQ-020 In CAPTURE, with x = captured col-3, the block SHALL copy window1[3r+k] = lb_r[x+k] and window2[3r+k] = lb_r[x+1+k], for r,k in 0..2, then go to START.
REQ-021 START SHALL drive o_conv_start=1 for exactly that one cycle and go to WAIT_DONE.
REQ-022 WAIT_DONE SHALL return to FILL on the cycle i_conv_done=1; i_conv_done SHALL be ignored in every other state.
REQ-023 Window read SHALL be combinational: o_windowN_data = windowN[i_window_addr] for addresses 0..8 and 0 for addresses 9..15.
REQ-024 Window registers SHALL remain stable from CAPTURE exit until the next CAPTURE.
REQ-025 o_frame_done SHALL pulse for one cycle on the WAIT_DONE->FILL transition of the window pair triggered by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-026 Windows per frame SHALL equal (IMG_HEIGHT-2)*(IMG_WIDTH-2)/2 pairs (stride 2).

Reset
REQ-027 On i_rst the block SHALL go to FILL, clear col, row and all window registers, and drive o_conv_start=0, o_frame_done=0, o_pix_ready=1 after release.
REQ-028 Reset mid-operation (any state) SHALL abandon the current window and frame; line buffer contents need not be cleared.

Structure
REQ-029 FSM state encodings and the window size constant (9) SHALL live in a shared package npu_pkg.
REQ-030 The three line buffers SHALL be one sub-module line_buffer3 (column-shift write, per-column read).

Verification
REQ-031 W=4,H=3, pixels 1..12, done returned 5 cycles after start -> one o_conv_start; window1 = 1,2,3,5,6,7,9,10,11; window2 = 2,3,4,6,7,8,10,11,12; o_frame_done pulse.
REQ-032 Same as REQ-031, read i_window_addr=9 and 15 -> both data outputs 0.
REQ-033 W=8,H=4, pixels 0..31 always valid -> exactly 6 o_conv_start pulses; o_pix_ready low from CAPTURE until done.
REQ-034 i_conv_done pulsed while in FILL -> no state change, no extra start.
REQ-035 Assert i_rst while in WAIT_DONE, then resend frame of REQ-031 -> identical outputs to REQ-031.
